pulse_seq_cmd: RTL and testbench
================================

Name: pulse_seq_cmd

Overview:
- Parametrised UART-commanded pulse sequencer for N channels.
- Parses fixed-length command frames from the byte stream out of uart_rx, validates them, and latches per-channel pulse widths, an inter-pulse gap and a channel enable mask.
- Emits the pulses on a trigger: either an accepted frame or an external key pulse.
- Runs entirely in the sys_clk domain; sits between uart_rx/key_control and the pulse/relay outputs.

Parameters:
- CH_NUM, 2, number of pulse channels (1..8).
- W_WIDTH, 16, width/gap counter width in bits; frame fields are 2 bytes big-endian, zero-extended or truncated to W_WIDTH.
- MIN_WIDTH, 4, minimum width/gap in sys_clk cycles; smaller values are clamped up to this.
- HEADER, 8'h07, frame header byte.
- TIMEOUT_CYC, 500000, inter-byte timeout in sys_clk cycles (10 ms at 50 MHz).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  synchronous active-low reset, sampled on the sys_clk rising edge.
- rx_data  in  8  received byte, valid when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from uart_rx (po_flag).
- trig_in  in  1  one-cycle trigger (key_en); reuses the current configuration.
- pulse_out  out  CH_NUM  pulse outputs, one bit per channel.
- busy  out  1  sequence in progress.
- frame_ok  out  1  one-cycle strobe: frame accepted.
- frame_err  out  1  one-cycle strobe: checksum failure or timeout.
- cfg_mask  out  CH_NUM  currently latched enable mask.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - pulse_out=0, busy=0, frame_ok=0, frame_err=0, cfg_mask=0.
  - All widths and the gap = MIN_WIDTH.
  - Parser in IDLE; pending=0.
  - Reset mid-sequence takes effect at that edge; no pulse completes.
- Frame format, length L = 2*CH_NUM+5 bytes:
  - byte 0: HEADER.
  - byte 1: mask; bit k enables channel k; bits >= CH_NUM ignored.
  - bytes 2..2*CH_NUM+1: width of ch0..chN-1, {hi,lo} pairs.
  - next 2 bytes: gap {hi,lo}.
  - last byte: checksum = 8-bit sum of all preceding bytes, mod 256.
  - CH_NUM=2 gives L=9.
- Parser FSM:
  - IDLE: a byte equal to HEADER -> RECV with byte count 1; any other byte is discarded silently.
  - RECV: store bytes; after byte L-1 -> CHECK.
  - CHECK (one cycle):
    - Checksum match -> commit mask, widths and gap to the config registers (clamped to MIN_WIDTH), pulse frame_ok, set pending=1.
    - Mismatch -> pulse frame_err, config unchanged.
    - Either way -> IDLE.
  - Timeout: in RECV, TIMEOUT_CYC cycles with no rx_valid -> IDLE, pulse frame_err; the partial frame is discarded.
  - An rx_valid arriving in the CHECK cycle is processed as an IDLE byte in the same cycle.
- Sequencer FSM: S_IDLE, S_PULSE, S_GAP.
  - Start condition: in S_IDLE with (trig_in | pending) and cfg_mask != 0. Config is snapshotted into working registers at the start edge; pending clears.
  - Start with mask=0: pending clears; no sequence, busy stays 0.
  - Channels fire in ascending index order, enabled channels only.
  - S_PULSE: the current channel's pulse_out bit is high for exactly width[k] cycles, starting the cycle after start.
  - S_GAP: all outputs low for exactly gap cycles, then the next enabled channel fires.
  - No gap after the last channel; busy falls in the same cycle the last pulse falls.
  - busy=1 from the first pulse cycle through the last pulse cycle.
  - At most one pulse_out bit is high at any time.
- Simultaneous and overlapping events:
  - trig_in while busy: ignored and not queued.
  - A frame accepted while busy: config updates immediately; the running sequence uses its snapshot; pending fires a new run on return to S_IDLE.
  - trig_in and pending in the same cycle: a single run.
- Counters saturate nowhere. Width and gap are each >= MIN_WIDTH >= 1, so there are no zero-length states.

Optional Feature:
- PULSE_REPEAT_EN defined:
  - One extra frame byte, rep, sits before the checksum; L = 2*CH_NUM+6.
  - The full sequence runs rep+1 times, with a gap inserted between repetitions.
  - rep=0 gives a single run.
  - busy stays high across all repetitions.
- PULSE_REPEAT_EN undefined: the frame has no rep byte; exactly one run per trigger.

Test Plan:
All cases use CH_NUM=2, TIMEOUT_CYC=1000 and the default frame format.
- Valid frame 07 03 00 0A 00 14 00 08 30 -> frame_ok one cycle after the last byte; pulse_out[0] high 10 cycles, low 8, pulse_out[1] high 20 cycles; busy high 38 cycles; cfg_mask=2'b11.
- Same frame with checksum 31 -> frame_err strobe; no pulses; cfg_mask unchanged (0 after reset).
- Widths and gap: 00 02 / 00 00 / 00 01 in frame 07 01 00 02 00 00 00 01 0B -> pulse_out[0] high exactly 4 cycles; pulse_out[1] never high.
- Timeout recovery: send 07 03 00 0A, then idle 1000 cycles -> frame_err. Then send the valid frame -> accepted normally.
- Retrigger behaviour:
  - After the first valid frame completes, trig_in -> identical 10/8/20 sequence.
  - trig_in pulsed mid-sequence -> ignored, no extra pulses.
- Reset mid-sequence: assert sys_rst_n=0 during the ch0 pulse -> pulse_out=0 and busy=0 at that edge. After release, trig_in produces nothing because cfg_mask=0.

Source files
------------

// File: rtl/pulse_seq_cmd.sv
// UART-commanded pulse sequencer: parses checksummed config frames and plays per-channel pulses on trigger.
// Optional macro PULSE_REPEAT_EN adds a repeat-count byte to the frame and repeats the whole sequence.
module pulse_seq_cmd #(
  parameter int          CH_NUM      = 2,
  parameter int          W_WIDTH     = 16,
  parameter int          MIN_WIDTH   = 4,
  parameter logic [7:0]  HEADER      = 8'h07,
  parameter int          TIMEOUT_CYC = 500000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              trig_in,
  output logic [CH_NUM-1:0] pulse_out,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [CH_NUM-1:0] cfg_mask
);

`ifdef PULSE_REPEAT_EN
  localparam int FRAME_LEN = 2*CH_NUM+6;
`else
  localparam int FRAME_LEN = 2*CH_NUM+5;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN+1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC+1);
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(FRAME_LEN-1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC-1);
  localparam logic [W_WIDTH-1:0] MIN_W    = W_WIDTH'(MIN_WIDTH);
  localparam logic [W_WIDTH-1:0] ONE_W    = W_WIDTH'(1);

  typedef enum logic [1:0] {P_IDLE, P_RECV, P_CHECK} p_state_t;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} s_state_t;

  // Frame fields are 16-bit; resize to the counter width, then clamp to the minimum.
  function automatic logic [W_WIDTH-1:0] clamp_field(input logic [15:0] v);
    logic [W_WIDTH-1:0] t;
    t = W_WIDTH'(v);
    return (t < MIN_W) ? MIN_W : t;
  endfunction

  function automatic logic [CH_NUM-1:0] onehot(input logic [CH_W-1:0] k);
    return CH_NUM'(1) << k;
  endfunction

  // Parser state
  p_state_t           p_state_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         sum_q;
  logic [7:0]         buf_q [FRAME_LEN];
  logic               frame_ok_q, frame_err_q;

  // Committed configuration
  logic [CH_NUM-1:0]  cfg_mask_q;
  logic [W_WIDTH-1:0] cfg_width_q [CH_NUM];
  logic [W_WIDTH-1:0] cfg_gap_q;
  logic               pending_q;

  // Sequencer working copy
  s_state_t           s_state_q;
  logic [CH_NUM-1:0]  w_mask_q;
  logic [W_WIDTH-1:0] w_width_q [CH_NUM];
  logic [W_WIDTH-1:0] w_gap_q;
  logic [CH_W-1:0]    ch_q;
  logic [W_WIDTH-1:0] tcnt_q;
  logic [CH_NUM-1:0]  pulse_q;
  logic               busy_q;

`ifdef PULSE_REPEAT_EN
  logic [7:0]         cfg_rep_q;
  logic [7:0]         rep_left_q;
`endif

  // Decoded frame fields
  logic [W_WIDTH-1:0] width_d [CH_NUM];
  logic [W_WIDTH-1:0] gap_d;
  logic [CH_NUM-1:0]  mask_d;
  logic               sum_ok_d;
  logic               commit_d;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_dec
    assign width_d[gi] = clamp_field({buf_q[2+2*gi], buf_q[3+2*gi]});
  end
  assign gap_d    = clamp_field({buf_q[2*CH_NUM+2], buf_q[2*CH_NUM+3]});
  assign mask_d   = buf_q[1][CH_NUM-1:0];
  assign sum_ok_d = (sum_q == buf_q[FRAME_LEN-1]);
  assign commit_d = (p_state_q == P_CHECK) && sum_ok_d;

  // Channel search: lowest enabled channel, and next enabled channel above ch_q.
  logic [CH_W-1:0] first_cfg_d, first_w_d, next_d;
  logic            has_next_d;
  always_comb begin
    first_cfg_d = '0;
    first_w_d   = '0;
    next_d      = '0;
    has_next_d  = 1'b0;
    for (int i = CH_NUM-1; i >= 0; i--) begin
      if (cfg_mask_q[i]) first_cfg_d = CH_W'(i);
      if (w_mask_q[i]) first_w_d = CH_W'(i);
      if (w_mask_q[i] && (CH_W'(i) > ch_q)) begin
        next_d     = CH_W'(i);
        has_next_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (p_state_q == P_RECV && rx_valid) buf_q[byte_cnt_q] <= rx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      p_state_q   <= P_IDLE;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      sum_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_mask_q  <= '0;
      cfg_gap_q   <= MIN_W;
      for (int i = 0; i < CH_NUM; i++) cfg_width_q[i] <= MIN_W;
`ifdef PULSE_REPEAT_EN
      cfg_rep_q   <= '0;
`endif
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (p_state_q)
        P_IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            p_state_q  <= P_RECV;
            byte_cnt_q <= CNT_W'(1);
            sum_q      <= rx_data;
            tmo_q      <= '0;
          end
        end
        P_RECV: begin
          if (rx_valid) begin
            tmo_q      <= '0;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            if (byte_cnt_q == LAST_IDX) p_state_q <= P_CHECK;
            else sum_q <= sum_q + rx_data;
          end else if (tmo_q == TMO_LAST) begin
            p_state_q   <= P_IDLE;
            frame_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        P_CHECK: begin
          if (sum_ok_d) begin
            cfg_mask_q  <= mask_d;
            cfg_width_q <= width_d;
            cfg_gap_q   <= gap_d;
`ifdef PULSE_REPEAT_EN
            cfg_rep_q   <= buf_q[2*CH_NUM+4];
`endif
            frame_ok_q  <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
          // A byte landing in this cycle is treated as if the parser were already idle.
          if (rx_valid && rx_data == HEADER) begin
            p_state_q  <= P_RECV;
            byte_cnt_q <= CNT_W'(1);
            sum_q      <= rx_data;
            tmo_q      <= '0;
          end else begin
            p_state_q  <= P_IDLE;
          end
        end
        default: p_state_q <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s_state_q <= S_IDLE;
      w_mask_q  <= '0;
      w_gap_q   <= MIN_W;
      for (int i = 0; i < CH_NUM; i++) w_width_q[i] <= MIN_W;
      ch_q      <= '0;
      tcnt_q    <= '0;
      pulse_q   <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
`ifdef PULSE_REPEAT_EN
      rep_left_q <= '0;
`endif
    end else begin
      case (s_state_q)
        S_IDLE: begin
          if (trig_in || pending_q) begin
            pending_q <= 1'b0;
            if (cfg_mask_q != '0) begin
              w_mask_q  <= cfg_mask_q;
              w_width_q <= cfg_width_q;
              w_gap_q   <= cfg_gap_q;
              ch_q      <= first_cfg_d;
              tcnt_q    <= cfg_width_q[first_cfg_d] - ONE_W;
              pulse_q   <= onehot(first_cfg_d);
              busy_q    <= 1'b1;
              s_state_q <= S_PULSE;
`ifdef PULSE_REPEAT_EN
              rep_left_q <= cfg_rep_q;
`endif
            end
          end
        end
        S_PULSE: begin
          if (tcnt_q == '0) begin
            pulse_q <= '0;
            if (has_next_d) begin
              ch_q      <= next_d;
              tcnt_q    <= w_gap_q - ONE_W;
              s_state_q <= S_GAP;
`ifdef PULSE_REPEAT_EN
            end else if (rep_left_q != '0) begin
              rep_left_q <= rep_left_q - 8'd1;
              ch_q       <= first_w_d;
              tcnt_q     <= w_gap_q - ONE_W;
              s_state_q  <= S_GAP;
`endif
            end else begin
              busy_q    <= 1'b0;
              s_state_q <= S_IDLE;
            end
          end else begin
            tcnt_q <= tcnt_q - ONE_W;
          end
        end
        S_GAP: begin
          if (tcnt_q == '0) begin
            pulse_q   <= onehot(ch_q);
            tcnt_q    <= w_width_q[ch_q] - ONE_W;
            s_state_q <= S_PULSE;
          end else begin
            tcnt_q <= tcnt_q - ONE_W;
          end
        end
        default: s_state_q <= S_IDLE;
      endcase
      // A frame accepted on the same edge as a start still leaves a run queued.
      if (commit_d) pending_q <= 1'b1;
    end
  end

`ifndef PULSE_REPEAT_EN
  logic unused_first_w;
  assign unused_first_w = ^first_w_d;
`endif

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign cfg_mask  = cfg_mask_q;

endmodule

// File: tb/tb_pulse_seq_cmd.sv
// Directed bench for pulse_seq_cmd (CH_NUM=2, TIMEOUT_CYC=1000): frame table plus hand-written corner sequences.
module tb_pulse_seq_cmd;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       trig_in = 1'b0;
  logic [1:0] pulse_out;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] cfg_mask;

  int n_checks = 0;
  int n_errors = 0;

  pulse_seq_cmd #(
    .CH_NUM(2),
    .W_WIDTH(16),
    .MIN_WIDTH(4),
    .HEADER(8'h07),
    .TIMEOUT_CYC(1000)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .trig_in(trig_in),
    .pulse_out(pulse_out),
    .busy(busy),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .cfg_mask(cfg_mask)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected observation of one measurement window; indices count samples taken 1 time unit after each edge.
  typedef struct packed {
    logic [71:0] frame;
    int ok_at;
    int err_at;
    int mask;
    int f0;
    int n0;
    int f1;
    int n1;
    int ngap;
    int nb;
  } vec_t;

  int n0, n1, ngap, nb, nmulti, nok, nerr, f0, l0, f1, l1, fok, ferr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [71:0] f, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      rx_data  = f[71-8*i -: 8];
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic measure(input int ncyc, input int ta, input int tb);
    n0 = 0; n1 = 0; ngap = 0; nb = 0; nmulti = 0; nok = 0; nerr = 0;
    f0 = -1; l0 = -1; f1 = -1; l1 = -1; fok = -1; ferr = -1;
    for (int i = 0; i < ncyc; i++) begin
      if (pulse_out[0]) begin n0++; if (f0 < 0) f0 = i; l0 = i; end
      if (pulse_out[1]) begin n1++; if (f1 < 0) f1 = i; l1 = i; end
      if (busy) nb++;
      if (busy && pulse_out == 2'b00) ngap++;
      if (pulse_out == 2'b11) nmulti++;
      if (frame_ok) begin nok++; if (fok < 0) fok = i; end
      if (frame_err) begin nerr++; if (ferr < 0) ferr = i; end
      if (i == ta || i == tb) trig_in = 1'b1;
      @(posedge sys_clk);
      #1;
      trig_in = 1'b0;
    end
  endtask

  task automatic check_run(input string tag, input vec_t v);
    chk({tag, " ch0_cycles"}, n0, v.n0);
    chk({tag, " ch0_first"}, f0, v.f0);
    chk({tag, " ch0_last"}, l0, (v.n0 > 0) ? v.f0 + v.n0 - 1 : -1);
    chk({tag, " ch1_cycles"}, n1, v.n1);
    chk({tag, " ch1_first"}, f1, v.f1);
    chk({tag, " ch1_last"}, l1, (v.n1 > 0) ? v.f1 + v.n1 - 1 : -1);
    chk({tag, " gap_cycles"}, ngap, v.ngap);
    chk({tag, " busy_cycles"}, nb, v.nb);
    chk({tag, " onehot"}, nmulti, 0);
    chk({tag, " ok_count"}, nok, (v.ok_at >= 0) ? 1 : 0);
    chk({tag, " ok_at"}, fok, v.ok_at);
    chk({tag, " err_count"}, nerr, (v.err_at >= 0) ? 1 : 0);
    chk({tag, " err_at"}, ferr, v.err_at);
    chk({tag, " cfg_mask"}, int'(cfg_mask), v.mask);
    $display("run %s: ch0=%0d@%0d ch1=%0d@%0d gap=%0d busy=%0d ok@%0d err@%0d mask=%0d",
             tag, n0, f0, n1, f1, ngap, nb, fok, ferr, cfg_mask);
  endtask

  localparam logic [71:0] F_GOOD  = 72'h07_03_000A_0014_0008_30;
  localparam logic [71:0] F_BAD   = 72'h07_03_000A_0014_0008_31;
  localparam logic [71:0] F_CLAMP = 72'h07_01_0002_0000_0001_0B;

  vec_t tbl [3];
  vec_t v_good, v_clamp, v_retrig, v_tmo, v_none;

  initial begin
    v_good   = '{frame: F_GOOD,  ok_at: 1,  err_at: -1, mask: 3, f0: 2,  n0: 10, f1: 20, n1: 20, ngap: 8, nb: 38};
    v_clamp  = '{frame: F_CLAMP, ok_at: 1,  err_at: -1, mask: 1, f0: 2,  n0: 4,  f1: -1, n1: 0,  ngap: 0, nb: 4};
    v_retrig = '{frame: F_GOOD,  ok_at: -1, err_at: -1, mask: 3, f0: 1,  n0: 10, f1: 19, n1: 20, ngap: 8, nb: 38};
    v_tmo    = '{frame: F_GOOD,  ok_at: -1, err_at: 1000, mask: 1, f0: -1, n0: 0, f1: -1, n1: 0, ngap: 0, nb: 0};
    v_none   = '{frame: F_GOOD,  ok_at: -1, err_at: -1, mask: 0, f0: -1, n0: 0,  f1: -1, n1: 0,  ngap: 0, nb: 0};
    tbl[0]   = '{frame: F_BAD,   ok_at: -1, err_at: 1,  mask: 0, f0: -1, n0: 0,  f1: -1, n1: 0,  ngap: 0, nb: 0};
    tbl[1]   = v_clamp;
    tbl[2]   = v_good;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset pulse_out", int'(pulse_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_ok", int'(frame_ok), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset cfg_mask", int'(cfg_mask), 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // A stray non-header byte must be dropped by the idle parser.
    send_frame(72'h55_00_0000_0000_0000_00, 1);

    for (int t = 0; t < 3; t++) begin
      send_frame(tbl[t].frame, 9);
      measure(60, -1, -1);
      check_run($sformatf("vec%0d", t), tbl[t]);
    end

    // Retrigger reuses the config; a trigger mid-sequence is ignored.
    measure(60, 0, 5);
    check_run("retrig", v_retrig);

    // Pending run and trig_in on the same edge give one run.
    send_frame(F_GOOD, 9);
    measure(80, 1, -1);
    check_run("trig+pending", v_good);

    // Timeout discards a partial frame and leaves the config alone.
    send_frame(F_CLAMP, 9);
    measure(60, -1, -1);
    check_run("pre_tmo", v_clamp);
    send_frame(F_GOOD, 4);
    measure(1010, -1, -1);
    check_run("timeout", v_tmo);
    send_frame(F_GOOD, 9);
    measure(60, -1, -1);
    check_run("post_tmo", v_good);

    // Reset during the ch0 pulse.
    trig_in = 1'b1;
    @(posedge sys_clk);
    #1;
    trig_in = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("midrun pulse_out", int'(pulse_out), 1);
    chk("midrun busy", int'(busy), 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst pulse_out", int'(pulse_out), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst cfg_mask", int'(cfg_mask), 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    measure(60, 0, -1);
    check_run("trig_after_rst", v_none);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
